// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// Serial transmit engine: a 4-entry byte FIFO fed by the UART controller's
// push interface, drained one byte at a time into 8N1 frames on o_txd.
//
// Handshake summary: i_tx_push is a one-cycle strobe. The push is accepted on
// the rising edge it is sampled at, unless the pre-edge count is 4. In that
// case the byte is discarded and o_tx_drop pulses for the following cycle.
// i_tx_start is a level request that is honoured only in IDLE when the FIFO
// holds at least one byte. The launch pops the head, and o_tx_start_clear
// pulses for exactly one cycle to acknowledge it.
//
// For checker binding, the FSM state is held in `state` (type state_t), and the
// FIFO occupancy in `fifo_cnt`.

module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_push,
  input  logic       i_tx_start,
  output logic       o_tx_start_clear,
  output logic [2:0] o_tx_fifo_cnt,
  output logic       o_tx_busy,
  output logic       o_tx_drop,
  output logic       o_txd
);

  // Baud counter width; it counts 0..CLKS_PER_BIT-1 within each bit period.
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;

  logic fifo_full;
  logic fifo_empty;
  logic push_ok;
  logic pop;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [2:0]    next_idx;

  // Fullness and emptiness are always judged on the pre-edge count. A pop in
  // the same cycle therefore does not make room for a push.
  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign push_ok    = i_tx_push && !fifo_full;
  assign pop        = (state == IDLE) && i_tx_start && !fifo_empty;
  assign next_idx   = bit_idx + 3'd1;

  assign o_tx_fifo_cnt = fifo_cnt;

  // FIFO data array: written on an accepted push. It is not reset because the
  // count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= i_tx_data;
    end
  end

  // FIFO pointers, occupancy count and the registered overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      fifo_cnt  <= 3'd0;
      o_tx_drop <= 1'b0;
    end else begin
      o_tx_drop <= i_tx_push && fifo_full;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE.
  // Every output level is set on the edge that enters a state, so the line
  // changes together with the state and no input reaches an output
  // combinationally. STOP always returns to IDLE for at least one cycle, so
  // back-to-back frames are spaced by 10*CLKS_PER_BIT+1 cycles.
  // ---------------------------------------------------------------------------
  // Sequences the frame and drives the registered line, busy and ack outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      baud_cnt         <= '0;
      bit_idx          <= 3'd0;
      shift_reg        <= 8'd0;
      o_txd            <= 1'b1;
      o_tx_busy        <= 1'b0;
      o_tx_start_clear <= 1'b0;
    end else begin
      o_tx_start_clear <= 1'b0;
      case (state)
        IDLE: begin
          o_txd     <= 1'b1;
          o_tx_busy <= 1'b0;
          if (pop) begin
            shift_reg        <= fifo_mem[rd_ptr];
            baud_cnt         <= '0;
            state            <= START;
            o_txd            <= 1'b0;
            o_tx_busy        <= 1'b1;
            o_tx_start_clear <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= DATA;
            o_txd    <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              o_txd <= 1'b1;
            end else begin
              bit_idx <= next_idx;
              o_txd   <= shift_reg[next_idx];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt  <= '0;
            state     <= IDLE;
            o_tx_busy <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        default: begin
          state     <= IDLE;
          o_txd     <= 1'b1;
          o_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
// Directed bench for uart_tx_engine with CLKS_PER_BIT=4. Inputs change and
// outputs are sampled 1ns after each rising edge.

module tb_uart_tx_engine;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_tx_data;
  logic       i_tx_push;
  logic       i_tx_start;
  logic       o_tx_start_clear;
  logic [2:0] o_tx_fifo_cnt;
  logic       o_tx_busy;
  logic       o_tx_drop;
  logic       o_txd;

  int total = 0;
  int bad   = 0;

  logic line_s [FRAME];

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       start;
    logic [2:0] exp_cnt;
    logic       exp_drop;
  } vec_t;

  vec_t vt [6];

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_tx_data        (i_tx_data),
    .i_tx_push        (i_tx_push),
    .i_tx_start       (i_tx_start),
    .o_tx_start_clear (o_tx_start_clear),
    .o_tx_fifo_cnt    (o_tx_fifo_cnt),
    .o_tx_busy        (o_tx_busy),
    .o_tx_drop        (o_tx_drop),
    .o_txd            (o_txd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    i_tx_push = 1'b1;
    i_tx_data = d;
    step();
    i_tx_push = 1'b0;
  endtask

  // Called at the sample right after a launch edge. Records the 40 line
  // samples, decodes the byte from the first sample of each data bit, and
  // checks that every bit level is held for CPB cycles.
  task automatic grab_frame(output logic [7:0] b, output int shape_ok, output int busy_hi);
    logic e;
    busy_hi  = 0;
    shape_ok = 1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) step();
      line_s[i] = o_txd;
      if (o_tx_busy === 1'b1) busy_hi++;
    end
    for (int k = 0; k < 8; k++) b[k] = line_s[(k + 1) * CPB];
    for (int g = 0; g < 10; g++) begin
      for (int j = 0; j < CPB; j++) begin
        if (g == 0)      e = 1'b0;
        else if (g == 9) e = 1'b1;
        else             e = b[g - 1];
        if (line_s[g * CPB + j] !== e) shape_ok = 0;
      end
    end
  endtask

  // Checks one complete frame, then the mandatory IDLE cycle after it.
  task automatic check_frame(input logic [7:0] exp_b, input string tag);
    logic [7:0] b;
    int         shape_ok;
    int         busy_hi;
    grab_frame(b, shape_ok, busy_hi);
    chk({tag, "_byte"}, b, exp_b);
    chk({tag, "_shape"}, shape_ok, 1);
    chk({tag, "_busy_len"}, busy_hi, FRAME);
    step();
    chk({tag, "_idle_busy"}, o_tx_busy, 1'b0);
  endtask

  // ---------------- scoreboard for the FIFO drain order ----------------
  logic [7:0] exp_q [$];

  // ---------------- test sequence ----------------
  initial begin
    int pulses;
    int busy_seen;
    int exp_lvl [10];
    logic [7:0] b;
    int shape_ok;
    int busy_hi;

    // Table for the fill/overflow sequence: the 5th push is discarded, with
    // the drop pulse visible right after the edge that rejected it.
    vt[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0};
    vt[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b0};
    vt[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b0};
    vt[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b0};
    vt[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1};
    vt[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b0};

    exp_lvl = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    rst_n      = 1'b0;
    i_tx_data  = 8'h00;
    i_tx_push  = 1'b0;
    i_tx_start = 1'b0;

    // ---- reset ----
    repeat (3) step();
    chk("rst_txd", o_txd, 1'b1);
    chk("rst_busy", o_tx_busy, 1'b0);
    chk("rst_cnt", o_tx_fifo_cnt, 3'd0);
    chk("rst_clear", o_tx_start_clear, 1'b0);
    chk("rst_drop", o_tx_drop, 1'b0);
    rst_n  = 1'b1;
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_tx_start_clear !== 1'b0 || o_tx_drop !== 1'b0) pulses++;
      if (o_tx_busy !== 1'b0 || o_txd !== 1'b1) busy_seen++;
    end
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_idle_line", busy_seen, 0);

    // ---- single frame 0xA5 ----
    push_byte(8'hA5);
    chk("single_cnt_push", o_tx_fifo_cnt, 3'd1);
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    chk("single_clear", o_tx_start_clear, 1'b1);
    chk("single_launch_txd", o_txd, 1'b0);
    chk("single_launch_busy", o_tx_busy, 1'b1);
    chk("single_cnt_pop", o_tx_fifo_cnt, 3'd0);
    grab_frame(b, shape_ok, busy_hi);
    chk("single_shape", shape_ok, 1);
    chk("single_busy_len", busy_hi, FRAME);
    for (int g = 0; g < 10; g++)
      chk($sformatf("single_lvl%0d", g), line_s[g * CPB + 1], exp_lvl[g]);
    step();
    chk("single_end_busy", o_tx_busy, 1'b0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_tx_start_clear !== 1'b0) pulses++;
    end
    chk("single_no_relaunch", pulses, 0);

    // ---- fill / overflow (table) ----
    for (int i = 0; i < 6; i++) begin
      i_tx_push  = vt[i].push;
      i_tx_data  = vt[i].data;
      i_tx_start = vt[i].start;
      step();
      if (vt[i].push && vt[i].exp_drop == 1'b0) exp_q.push_back(vt[i].data);
      chk($sformatf("fill%0d_cnt", i), o_tx_fifo_cnt, vt[i].exp_cnt);
      chk($sformatf("fill%0d_drop", i), o_tx_drop, vt[i].exp_drop);
    end
    i_tx_push = 1'b0;

    // ---- drain, with a push-while-full on the launch cycle ----
    i_tx_start = 1'b1;
    i_tx_push  = 1'b1;
    i_tx_data  = 8'h99;
    step();
    i_tx_push  = 1'b0;
    chk("drain_full_pop_drop", o_tx_drop, 1'b1);
    chk("drain_full_pop_cnt", o_tx_fifo_cnt, 3'd3);
    chk("drain_clear0", o_tx_start_clear, 1'b1);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) begin
        step();
        chk($sformatf("drain_spacing%0d", f), o_tx_start_clear, 1'b1);
      end
      check_frame(exp_q.pop_front(), $sformatf("drain%0d", f));
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_tx_start_clear !== 1'b0) pulses++;
    end
    chk("drain_empty_pulses", pulses, 0);
    chk("drain_final_cnt", o_tx_fifo_cnt, 3'd0);
    i_tx_start = 1'b0;

    // ---- simultaneous push and pop ----
    push_byte(8'h31);
    push_byte(8'h42);
    chk("sim_cnt_before", o_tx_fifo_cnt, 3'd2);
    i_tx_start = 1'b1;
    i_tx_push  = 1'b1;
    i_tx_data  = 8'h7E;
    step();
    i_tx_push  = 1'b0;
    chk("sim_cnt_after", o_tx_fifo_cnt, 3'd2);
    chk("sim_clear", o_tx_start_clear, 1'b1);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h7E);
    for (int f = 0; f < 3; f++) begin
      if (f > 0) begin
        step();
        chk($sformatf("sim_spacing%0d", f), o_tx_start_clear, 1'b1);
      end
      check_frame(exp_q.pop_front(), $sformatf("sim%0d", f));
    end
    i_tx_start = 1'b0;
    step();
    chk("sim_final_cnt", o_tx_fifo_cnt, 3'd0);

    // ---- reset mid-frame during data bit 3 ----
    push_byte(8'h52);
    push_byte(8'h6B);
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;
    chk("mid_clear", o_tx_start_clear, 1'b1);
    chk("mid_cnt", o_tx_fifo_cnt, 3'd1);
    repeat (4 * CPB + 1) step();
    chk("mid_bit3_low", o_txd, 1'b0);
    chk("mid_busy_before", o_tx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", o_txd, 1'b1);
    chk("mid_rst_busy", o_tx_busy, 1'b0);
    chk("mid_rst_cnt", o_tx_fifo_cnt, 3'd0);
    repeat (2) step();
    rst_n      = 1'b1;
    i_tx_start = 1'b1;
    pulses    = 0;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_tx_start_clear !== 1'b0) pulses++;
      if (o_tx_busy !== 1'b0 || o_txd !== 1'b1) busy_seen++;
    end
    chk("mid_after_pulses", pulses, 0);
    chk("mid_after_idle", busy_seen, 0);
    chk("mid_after_cnt", o_tx_fifo_cnt, 3'd0);
    i_tx_start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmit engine for the user-project UART. It sits behind the Wishbone UART controller and accepts bytes on the controller's push/start interface into a 4-entry FIFO. It serialises each byte as an 8N1 frame on `o_txd` and reports FIFO occupancy, busy status and a start-acknowledge pulse back to the controller.

## Interface
- `CLKS_PER_BIT`, default 104: clk cycles per serial bit; legal range 2..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_tx_data`  in  8  byte to enqueue, sampled when `i_tx_push`=1.
- `i_tx_push`  in  1  enqueue strobe, one byte per cycle high.
- `i_tx_start`  in  1  transmit request, level-sensitive.
- `o_tx_start_clear`  out  1  one-cycle pulse when a frame is launched (FIFO pop).
- `o_tx_fifo_cnt`  out  3  FIFO occupancy, 0..4.
- `o_tx_busy`  out  1  high while a frame is on the line.
- `o_tx_drop`  out  1  one-cycle pulse when a push is discarded because the FIFO is full.
- `o_txd`  out  1  serial line; idles high.

## Operation
- FIFO:
  - 4 entries x 8 bits, 2-bit write/read pointers wrapping 3->0.
  - Count is held in a 3-bit register.
  - Push when count<4 writes `i_tx_data` at the write pointer and increments the pointer.
  - Push when count==4 is discarded: `o_tx_drop`=1 next cycle, and FIFO contents, pointers and count are unchanged.
- Pop and push in the same cycle:
  - Both take effect and the count is unchanged.
  - Push-while-full is still discarded even if a pop happens in the same cycle; fullness is judged on the pre-edge count.
- The FSM has four states, IDLE, START, DATA and STOP, plus a 3-bit bit index and a baud counter of width clog2(`CLKS_PER_BIT`).
- IDLE:
  - `o_txd`=1, `o_tx_busy`=0.
  - If `i_tx_start`=1 and count>0: pop the head into the shift register, go to START, clear the baud counter, and assert `o_tx_start_clear` for one cycle.
  - If `i_tx_start`=1 and count==0: no action.
- START: `o_txd`=0 for `CLKS_PER_BIT` cycles, then DATA with bit index 0.
- DATA:
  - `o_txd` = shift[index], LSB first, each bit for `CLKS_PER_BIT` cycles.
  - After index 7, go to STOP.
- STOP: `o_txd`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- `o_tx_busy`=1 in START, DATA and STOP.
- Back-to-back frames: every frame returns to IDLE for at least one cycle, during which `o_tx_busy`=0. The next launch requires `i_tx_start` to be high in an IDLE cycle.
- `i_tx_start` is ignored outside IDLE, and `i_tx_push` is accepted in every state.
- `o_txd`, `o_tx_busy`, `o_tx_start_clear` and `o_tx_drop` are all registered, with no combinational path from any input to any output.

## Timing
- Reset values while `rst_n`=0:
  - `o_txd`=1, `o_tx_busy`=0, `o_tx_start_clear`=0, `o_tx_drop`=0, `o_tx_fifo_cnt`=0.
  - Pointers 0, FSM in IDLE, shift register 0.
- Reset mid-frame: the line returns to 1 immediately (asynchronous) and all queued bytes are lost.
- Push at edge N: `o_tx_fifo_cnt` reflects the push after edge N.
- Launch, with `i_tx_start` and count>0 sampled in IDLE at edge N:
  - After edge N: `o_txd`=0, `o_tx_busy`=1, `o_tx_start_clear`=1, count decremented.
  - After edge N+1: `o_tx_start_clear`=0.
- Frame length is exactly 10*`CLKS_PER_BIT` cycles of `o_tx_busy`=1.
  - The start bit occupies cycles N+1..N+`CLKS_PER_BIT`.
  - Data bit k begins at N+1+(k+1)*`CLKS_PER_BIT`.
- Minimum launch-to-launch spacing is 10*`CLKS_PER_BIT`+1 cycles.
- Throughput is one push per cycle into the FIFO, up to 4 outstanding bytes.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, release -> `o_txd`=1, `o_tx_busy`=0, `o_tx_fifo_cnt`=0; no pulses for 20 cycles.
- Single frame with `CLKS_PER_BIT`=4: push 0xA5, then `i_tx_start`=1 -> `o_tx_start_clear` pulses once; line reads 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles; `o_tx_busy` high for exactly 40 cycles; count goes 1->0.
- Fill/overflow: push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles with `i_tx_start`=0 -> count reaches 4; `o_tx_drop` pulses once, one cycle after the 5th push; count stays 4.
- Drain order: from the full FIFO above, hold `i_tx_start`=1 -> frames carry 0x11, 0x22, 0x33, 0x44 in order; each is followed by 1 IDLE cycle with `o_tx_busy`=0; the final count is 0.
- Simultaneous push/pop: count=2 in IDLE, `i_tx_start`=1 and push 0x7E in the same cycle -> count stays 2 and the launched frame carries the older head byte; 0x7E is transmitted last.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3 -> `o_txd`=1 and `o_tx_busy`=0 immediately; after release, count=0 and no frame starts even with `i_tx_start`=1.
